// File: rtl/debounce_pulse.sv
// Button debouncer with press/release strobes; DEBOUNCE_PULSE_REPEAT_EN adds auto-repeat
// press pulses while the button stays held.
module debounce_pulse #(
  parameter int CNT_W         = 16,
  parameter int STABLE        = 1000,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse,
  output logic rel_pulse
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sync1_r;
  logic             sync_r;
  logic             level_r;
  logic             pulse_r;
  logic             rel_pulse_r;
  logic             rep_fire_s;

  // two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync_r  <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync_r  <= sync1_r;
    end
  end

`ifdef DEBOUNCE_PULSE_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_M1  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt_r;
  logic             press_accept_s;
  logic             release_done_s;
  logic             rep_active_s;

  assign press_accept_s = (state_r == PRESS_WAIT) && sync_r && (cnt_r == STABLE_M1);
  assign release_done_s = (state_r == RELEASE_WAIT) && !sync_r && (cnt_r == STABLE_M1);
  assign rep_active_s   = (state_r == HELD) || (state_r == RELEASE_WAIT);
  assign rep_fire_s     = rep_active_s && (rcnt_r == {CNT_W{1'b0}});

  // down-counter to the next repeat pulse; loaded by the press, reloaded on each repeat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_r <= {CNT_W{1'b0}};
    end else if (press_accept_s) begin
      rcnt_r <= DELAY_M1;
    end else if (release_done_s || !rep_active_s) begin
      rcnt_r <= {CNT_W{1'b0}};
    end else if (rcnt_r == {CNT_W{1'b0}}) begin
      rcnt_r <= PERIOD_M1;
    end else begin
      rcnt_r <= rcnt_r - CNT_W'(1);
    end
  end
`else
  logic unused_repeat_cfg_s;

  assign rep_fire_s          = 1'b0;
  assign unused_repeat_cfg_s = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  // debounce FSM with registered level and strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      level_r     <= 1'b0;
      pulse_r     <= 1'b0;
      rel_pulse_r <= 1'b0;
    end else begin
      pulse_r     <= 1'b0;
      rel_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sync_r) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!sync_r) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == STABLE_M1) begin
            state_r <= HELD;
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b1;
            pulse_r <= 1'b1;
          end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        HELD: begin
          pulse_r <= rep_fire_s;
          if (!sync_r) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            state_r <= HELD;
          end
        end
        RELEASE_WAIT: begin
          // a bounce back to high resumes HELD silently
          if (sync_r) begin
            state_r <= HELD;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == STABLE_M1) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            level_r     <= 1'b0;
            rel_pulse_r <= 1'b1;
          end else begin
            pulse_r <= rep_fire_s;
            if (cnt_r != {CNT_W{1'b1}}) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          level_r <= 1'b0;
        end
      endcase
    end
  end

  assign level     = level_r;
  assign pulse     = pulse_r;
  assign rel_pulse = rel_pulse_r;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed self-checking bench for debounce_pulse (STABLE=4, repeat delay 10, period 3).
module tb_debounce_pulse;

  localparam int CNT_W         = 8;
  localparam int STABLE        = 4;
  localparam int REPEAT_DELAY  = 10;
  localparam int REPEAT_PERIOD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic level;
  logic pulse;
  logic rel_pulse;

  int errors = 0;
  int checks = 0;

  logic [3:0] q;
  logic       ov;
  logic       ov_seen;
  logic       cnt_clr = 1'b1;

  debounce_pulse #(
    .CNT_W        (CNT_W),
    .STABLE       (STABLE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .level    (level),
    .pulse    (pulse),
    .rel_pulse(rel_pulse)
  );

  always #5 clk = ~clk;

  // decade counter enabled by the press strobe
  assign ov = pulse && (q == 4'd9);
  always_ff @(posedge clk) begin
    if (cnt_clr) begin
      q       <= 4'd0;
      ov_seen <= 1'b0;
    end else begin
      if (pulse) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      if (ov) ov_seen <= 1'b1;
    end
  end

  function automatic logic exp_pulse(int i, int p, int e);
    logic r;
    r = (i == p) && (i < e);
`ifdef DEBOUNCE_PULSE_REPEAT_EN
    if ((i >= p + REPEAT_DELAY) && (i < e) && (((i - p - REPEAT_DELAY) % REPEAT_PERIOD) == 0))
      r = 1'b1;
`endif
    return r;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // outputs after edge i of a press accepted at edge p and released at edge e
  task automatic chk_cycle(string name, int i, int p, int e);
    chk($sformatf("%s pulse@%0d", name, i), {15'd0, pulse}, {15'd0, exp_pulse(i, p, e)});
    chk($sformatf("%s level@%0d", name, i), {15'd0, level}, {15'd0, (i >= p) && (i < e)});
    chk($sformatf("%s rel@%0d", name, i), {15'd0, rel_pulse}, {15'd0, i == e});
    chk($sformatf("%s excl@%0d", name, i), {15'd0, pulse & rel_pulse}, 16'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset level", {15'd0, level}, 16'd0);
    chk("reset pulse", {15'd0, pulse}, 16'd0);
    chk("reset rel", {15'd0, rel_pulse}, 16'd0);
    rst = 1'b1;
    repeat (3) tick();
    chk("idle level", {15'd0, level}, 16'd0);

    // clean press held long, then released at edge 37
    for (int i = 0; i < 47; i++) begin
      btn = (i < 37);
      tick();
      chk_cycle("clean", i, 6, 43);
    end

    // one-cycle glitch low at edge 8, real release at edge 15
    for (int i = 0; i < 25; i++) begin
      btn = (i < 15) && (i != 8);
      tick();
      chk_cycle("glitch", i, 6, 21);
    end

    // bounce for 6 cycles, steady from edge 6, released at edge 16
    for (int i = 0; i < 26; i++) begin
      btn = (i < 6) ? ((i % 2) == 0) : (i < 16);
      tick();
      chk_cycle("bounce", i, 12, 22);
    end

    // reset across edges 4..7 of a press; btn stays high through release
    for (int i = 0; i < 30; i++) begin
      rst = !((i >= 4) && (i < 8));
      btn = (i < 20);
      tick();
      chk_cycle("rstmid", i, 14, 26);
    end

    // asynchronous reset while HELD clears level at once
    for (int i = 0; i < 8; i++) begin
      btn = 1'b1;
      tick();
      chk_cycle("held", i, 6, 100);
    end
    rst = 1'b0;
    #1;
    chk("async level", {15'd0, level}, 16'd0);
    chk("async pulse", {15'd0, pulse}, 16'd0);
    tick();
    btn = 1'b0;
    rst = 1'b1;
    repeat (6) tick();
    chk("post-reset level", {15'd0, level}, 16'd0);
    chk("post-reset rel", {15'd0, rel_pulse}, 16'd0);

    // three clean presses counted by the decade counter
    cnt_clr = 1'b0;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 20; i++) begin
        btn = (i < 10);
        tick();
        chk_cycle($sformatf("count%0d", n), i, 6, 16);
      end
    end
    chk("counter q", {12'd0, q}, 16'd3);
    chk("counter ov", {15'd0, ov_seen}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the debounce and repeat counters.
REQ-002 SHALL have parameter STABLE, default 1000, giving the number of consecutive stable cycles needed to accept a level change (legal range 1..2^CNT_W-1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000, giving the cycles from press pulse to first repeat pulse; used only when the repeat feature is compiled in.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10000, giving the cycles between subsequent repeat pulses; used only when the repeat feature is compiled in.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port btn, input, 1 bit: raw asynchronous button, active-high.
REQ-008 SHALL have port level, output, 1 bit: debounced button level.
REQ-009 SHALL have port pulse, output, 1 bit: one-cycle press strobe, sized to drive a downstream counter ce directly.
REQ-010 SHALL have port rel_pulse, output, 1 bit: one-cycle release strobe.

Function
REQ-011 SHALL pass btn through a two-flop synchronizer; only the second flop output (sync) feeds logic.
REQ-012 SHALL implement a registered FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-013 IDLE: sync=1 -> PRESS_WAIT with cnt cleared to 0; otherwise stay in IDLE.
REQ-014 PRESS_WAIT: sync=0 -> IDLE with cnt cleared; sync=1 and cnt=STABLE-1 -> HELD; otherwise cnt+1.
REQ-015 SHALL assert level and pulse on the edge entering HELD; pulse SHALL be high for exactly one cycle.
REQ-016 Latency: btn first sampled high at edge k and held -> pulse high during the cycle after edge k+2+STABLE.
REQ-017 HELD: sync=0 -> RELEASE_WAIT with cnt cleared; otherwise stay in HELD.
REQ-018 RELEASE_WAIT: sync=1 -> HELD with cnt cleared, no pulse and no rel_pulse; sync=0 and cnt=STABLE-1 -> IDLE, with level deasserted and rel_pulse asserted for one cycle on that edge.
REQ-019 Counters SHALL saturate at all-ones and never wrap.
REQ-020 pulse and rel_pulse SHALL never be high in the same cycle.
REQ-021 level SHALL change only on FSM transitions into HELD or IDLE.

Reset
REQ-022 rst=0 SHALL immediately force state IDLE, cnt=0, repeat counter=0, synchronizer flops=0, and level=pulse=rel_pulse=0.
REQ-023 Reset during PRESS_WAIT or RELEASE_WAIT SHALL abandon the debounce; no strobe is emitted for it.
REQ-024 btn held high across reset deassertion SHALL be treated as a new press: one pulse after a full debounce interval (REQ-016 timing, with k = first edge after release).

Configuration
REQ-025 With macro DEBOUNCE_PULSE_REPEAT_EN defined, HELD SHALL run a repeat counter from the press pulse and emit additional one-cycle pulses REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles, while in HELD or RELEASE_WAIT.
REQ-026 With DEBOUNCE_PULSE_REPEAT_EN undefined, exactly one pulse SHALL be emitted per accepted press, and no repeat logic SHALL be synthesized.
REQ-027 The repeat counter SHALL clear on leaving HELD or RELEASE_WAIT toward IDLE.

Verification (STABLE=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=8)
REQ-028 Clean press: reset released, btn=1 from edge 0 for 20 cycles -> pulse high only in the cycle after edge 6; level=1 from edge 6.
REQ-029 Bounce: btn toggles 1/0 every cycle for 6 cycles, then stays 1 from edge 6 -> no pulse during the bounce; single pulse in the cycle after edge 12.
REQ-030 Release and glitch: with level=1, drop btn for 1 cycle -> no rel_pulse and level stays 1; drop btn permanently at edge m -> rel_pulse in the cycle after edge m+6, with level=0 on the same edge.
REQ-031 Repeat: macro defined, btn held 30 cycles past the press pulse at edge p -> pulses at p, p+10, p+13, p+16, and so on; macro undefined -> pulse at p only.
REQ-032 Reset mid-debounce: rst=0 at edge 4 of a press, released at edge 8 with btn still 1 -> all outputs 0 during reset; pulse in the cycle after edge 14.
REQ-033 Integration: pulse drives ce of an N=10 counter; 3 clean presses -> counter q=3, and ov=0 throughout.
